// File: rtl/dmem_write_loader.sv
// Packs a host byte stream (low byte first) into 16-bit words and writes them to consecutive data-memory addresses.
// Optional running word checksum output when DMEM_WRITE_LOADER_CHECKSUM_EN is defined.
module dmem_write_loader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_count,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_we,
    output logic [1:0]        addr_mux_select,
`ifdef DMEM_WRITE_LOADER_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LO    = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [15:0]       remaining_q, remaining_d;
    logic              rx_hs;

    assign rx_hs = rx_valid && rx_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        remaining_d = remaining_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = word_count;
                    state_d     = (word_count == 16'd0) ? S_DONE : S_LO;
                end
            end
            S_LO: begin
                if (rx_hs) begin
                    wdata_d[7:0] = rx_data;
                    state_d      = S_HI;
                end
            end
            S_HI: begin
                if (rx_hs) begin
                    wdata_d[15:8] = rx_data;
                    state_d       = S_WRITE;
                end
            end
            S_WRITE: begin
                // Address wraps naturally at the top of the memory.
                addr_d      = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                remaining_d = remaining_q - 16'd1;
                state_d     = (remaining_q == 16'd1) ? S_DONE : S_LO;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            remaining_q <= remaining_d;
        end
    end

`ifdef DMEM_WRITE_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_IDLE && start) begin
            checksum_d = 16'd0;
        end else if (state_q == S_WRITE) begin
            checksum_d = checksum_q + wdata_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum_q <= 16'd0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    // Every output is a state decode or a register, so rx_ready never depends on rx_valid.
    assign rx_ready        = (state_q == S_LO) || (state_q == S_HI);
    assign dmem_we         = (state_q == S_WRITE);
    assign addr_mux_select = {1'b0, rx_ready || dmem_we};
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);
    assign dmem_addr       = addr_q;
    assign dmem_wdata      = wdata_q;

endmodule
